input_debouncer: RTL and testbench

//  Multi-channel input conditioner sitting directly upstream of the counter on ui_in.
//  Per channel: synchronises a raw pad input and filters bounce by requiring stability.

---
 rtl/input_debouncer_pkg.sv | 20 ++
 rtl/input_debouncer_if.sv | 35 +++
 rtl/input_debouncer_channel.sv | 151 +++++++++++++++
 rtl/input_debouncer.sv | 41 ++++
 tb/tb_input_debouncer.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/input_debouncer_pkg.sv
// ============================================================================
// input_debouncer_pkg : shared types and constants for the input debouncer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package input_debouncer_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } deb_state_t;

  localparam int SYNC_STAGES = 2;

endpackage : input_debouncer_pkg

`default_nettype wire

// File: rtl/input_debouncer_if.sv
// ============================================================================
// input_debouncer_if : raw inputs / conditioned outputs bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface input_debouncer_if #(
  parameter int WIDTH = 4
);

  logic             ena;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output ena,
    output raw_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  ena,
    input  raw_in,
    output level_out,
    output rise_pulse,
    output fall_pulse
  );

endinterface : input_debouncer_if

`default_nettype wire

// File: rtl/input_debouncer_channel.sv
// ============================================================================
// debounce_channel : one channel - 2-FF sync, stability FSM, optional repeat
// Optional feature macro: INPUT_DEBOUNCER_AUTOREPEAT_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000,
  parameter int REPEAT_RATE     = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s2;
  deb_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc_d;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   rep_fire_d;

  assign s2        = sync_q[SYNC_STAGES-1];
  assign cnt_inc_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

`ifdef INPUT_DEBOUNCER_AUTOREPEAT_EN
  logic [CNT_W-1:0] rcnt_q;
  logic             rep_q;
  logic             rep_hit;

  // First interval is REPEAT_DELAY, later ones REPEAT_RATE; rep_q selects which.
  assign rep_hit    = (rcnt_q == (rep_q ? CNT_W'(REPEAT_RATE - 1) : CNT_W'(REPEAT_DELAY - 1)));
  assign rep_fire_d = (state_q == HIGH) && ena_i && s2 && rep_hit;

  always_ff @(posedge clk) begin
    if (rst || (state_q != HIGH)) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else if (ena_i && s2) begin
      if (rep_hit) begin
        rcnt_q <= '0;
        rep_q  <= 1'b1;
      end else begin
        rcnt_q <= rcnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign rep_fire_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (ena_i) begin
        case (state_q)
          LOW: begin
            if (s2) begin
              if (ONE_SHOT) begin
                state_q <= HIGH;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                state_q <= CHK_HIGH;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
          CHK_HIGH: begin
            if (!s2) begin
              state_q <= LOW;
              cnt_q   <= '0;
            end else if (cnt_q == LAST) begin
              state_q <= HIGH;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          HIGH: begin
            if (!s2) begin
              if (ONE_SHOT) begin
                state_q <= LOW;
                level_q <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                state_q <= CHK_LOW;
                cnt_q   <= CNT_W'(1);
              end
            end else begin
              rise_q <= rep_fire_d;
            end
          end
          CHK_LOW: begin
            if (s2) begin
              state_q <= HIGH;
              cnt_q   <= '0;
            end else if (cnt_q == LAST) begin
              state_q <= LOW;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          default: begin
            state_q <= LOW;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
// input_debouncer : WIDTH independent debounce channels with edge pulses
// Optional feature macro: INPUT_DEBOUNCER_AUTOREPEAT_EN (rise auto-repeat)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000,
  parameter int REPEAT_RATE     = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input_debouncer_if.slave    bus
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .ena_i   (bus.ena),
      .raw_i   (bus.raw_in[i]),
      .level_o (bus.level_out[i]),
      .rise_o  (bus.rise_pulse[i]),
      .fall_o  (bus.fall_pulse[i])
    );
  end

endmodule : input_debouncer

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
// tb_input_debouncer : directed self-checking bench for input_debouncer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;
  import input_debouncer_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 16;
  localparam int DEB   = 4;
  localparam int RDLY  = 8;
  localparam int RRATE = 3;

`ifdef INPUT_DEBOUNCER_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  input_debouncer_if #(.WIDTH(WIDTH)) bus ();

  input_debouncer #(
    .WIDTH           (WIDTH),
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_RATE     (RRATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_rise3;

    // 1: reset with all raw inputs high
    rst        = 1'b1;
    bus.ena    = 1'b1;
    bus.raw_in = 4'hF;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_level", bus.level_out, 4'h0);
      chk("rst_rise",  bus.rise_pulse, 4'h0);
      chk("rst_fall",  bus.fall_pulse, 4'h0);
    end
    rst        = 1'b0;
    bus.raw_in = 4'h0;
    step();
    chk("post_rst_level", bus.level_out, 4'h0);
    chk("post_rst_rise",  bus.rise_pulse, 4'h0);
    chk("post_rst_fall",  bus.fall_pulse, 4'h0);
    for (int k = 0; k < 3; k++) step();

    // 2: clean rise on channel 0, accepted on the 6th edge
    bus.raw_in = 4'h1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("ch0_rise_level", bus.level_out,  (k >= 6) ? 4'h1 : 4'h0);
      chk("ch0_rise_pulse", bus.rise_pulse, (k == 6) ? 4'h1 : 4'h0);
      chk("ch0_rise_fall",  bus.fall_pulse, 4'h0);
    end

    // 3: two-cycle glitch on channel 1 is rejected
    for (int k = 1; k <= 10; k++) begin
      bus.raw_in = (k <= 2) ? 4'h3 : 4'h1;
      step();
      chk("glitch_level", bus.level_out,  4'h1);
      chk("glitch_rise",  bus.rise_pulse, 4'h0);
    end
    chk("glitch_cnt",   dut.g_ch[1].u_ch.cnt_q, 0);
    chk("glitch_state", dut.g_ch[1].u_ch.state_q, LOW);

    // 4: channel 0 falls while frozen, then resolves after enable returns
    bus.ena    = 1'b0;
    bus.raw_in = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("frozen_level", bus.level_out,  4'h1);
      chk("frozen_fall",  bus.fall_pulse, 4'h0);
    end
    bus.ena = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("resume_level", bus.level_out,  (k >= 4) ? 4'h0 : 4'h1);
      chk("resume_fall",  bus.fall_pulse, (k == 4) ? 4'h1 : 4'h0);
      chk("resume_rise",  bus.rise_pulse, 4'h0);
    end

    // 5: reset in the middle of a channel 2 check
    bus.raw_in = 4'h4;
    for (int k = 0; k < 4; k++) step();
    chk("mid_cnt",   dut.g_ch[2].u_ch.cnt_q, 2);
    chk("mid_state", dut.g_ch[2].u_ch.state_q, CHK_HIGH);
    rst        = 1'b1;
    bus.raw_in = 4'h0;
    step();
    chk("midrst_cnt",   dut.g_ch[2].u_ch.cnt_q, 0);
    chk("midrst_state", dut.g_ch[2].u_ch.state_q, LOW);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("midrst_level", bus.level_out,  4'h0);
      chk("midrst_rise",  bus.rise_pulse, 4'h0);
    end

    // 6: channel 3 held high for 30 cycles (auto-repeat in macro builds)
    for (int k = 1; k <= 40; k++) begin
      bus.raw_in = (k <= 30) ? 4'h8 : 4'h0;
      step();
      exp_rise3 = (k == 6) ||
                  (AUTOREP && k >= 14 && k <= 32 && ((k - 14) % 3 == 0));
      chk("hold_rise",  bus.rise_pulse, {exp_rise3, 3'b000});
      chk("hold_level", bus.level_out,  (k >= 6 && k < 36) ? 4'h8 : 4'h0);
      chk("hold_fall",  bus.fall_pulse, (k == 36) ? 4'h8 : 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_input_debouncer

`default_nettype wire
